// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I-cache, D-cache, shared memory and the arbiter.
// The slave modport is the arbiter's view: it serves the two cache
// requesters and forwards the granted one onto the memory side. The master
// modport is the view of the surrounding system (caches plus memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    // I-cache requester
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    // D-cache requester
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    // Shared memory port
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        input  d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        output d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single shared memory port.
// A grant is held for a whole transaction (until mem_ready, or until the
// granted requester withdraws its strobes); every transaction is followed by
// one IDLE cycle, where the next winner is picked. Ties alternate using a
// one-bit last-grant register that resets to D so that I wins the first tie.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;

    logic              i_pend;
    logic              d_pend;

    logic              mem_read_c;
    logic              mem_write_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              i_ready_c;
    logic              d_ready_c;

    assign i_pend = bus.i_read | bus.i_write;
    assign d_pend = bus.d_read | bus.d_write;

    // State and round-robin history registers; reset acts without a clock.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q    <= IDLE;
            last_gnt_q <= LAST_D;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state: pick a winner in IDLE, hold the grant until done/withdrawn.
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            IDLE: begin
                // I wins when alone, or on a tie when D was served last.
                if (i_pend && (!d_pend || last_gnt_q == LAST_D)) begin
                    state_d    = GNT_I;
                    last_gnt_d = LAST_I;
                end else if (d_pend) begin
                    state_d    = GNT_D;
                    last_gnt_d = LAST_D;
                end
            end
            GNT_I: begin
                if (bus.mem_ready || !i_pend) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (bus.mem_ready || !d_pend) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mux: route the granted requester to memory, return its ready.
    // A simultaneous read+write is issued as a write only.
    always_comb begin
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        i_ready_c   = 1'b0;
        d_ready_c   = 1'b0;
        unique case (state_q)
            GNT_I: begin
                mem_write_c = bus.i_write;
                mem_read_c  = bus.i_read & ~bus.i_write;
                mem_addr_c  = bus.i_addr;
                mem_wdata_c = bus.i_wdata;
                i_ready_c   = bus.mem_ready;
            end
            GNT_D: begin
                mem_write_c = bus.d_write;
                mem_read_c  = bus.d_read & ~bus.d_write;
                mem_addr_c  = bus.d_addr;
                mem_wdata_c = bus.d_wdata;
                d_ready_c   = bus.mem_ready;
            end
            default: begin
                // IDLE (and reset, which forces IDLE): memory port quiet.
            end
        endcase
    end

    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.i_ready   = i_ready_c;
    assign bus.d_ready   = d_ready_c;

    // Read data is broadcast; only the requester seeing ready consumes it.
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all checked every cycle against a transaction-level
// model of who owns the memory port.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic clk;
    logic proc_reset;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner of the memory port (0 none, 1 I, 2 D) and the
    // requester served most recently (1 I, 2 D).
    int owner = 0;
    int last_served = 2;
    bit exp_i_rdy;
    bit exp_d_rdy;
    int done_q[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
    endtask

    // Called at a negedge with inputs applied: checks this cycle's outputs,
    // advances the model across the next rising edge, returns at the negedge.
    task automatic step();
        bit ip, dp;
        int nxt;
        logic [3:0] ctl_e;
        logic [AW-1:0] addr_e;
        logic [DW-1:0] wdata_e;
        #1;
        if (proc_reset) begin
            owner = 0;
            last_served = 2;
        end
        ip = bus.i_read | bus.i_write;
        dp = bus.d_read | bus.d_write;
        ctl_e = 4'b0; addr_e = '0; wdata_e = '0;
        if (owner == 1) begin
            ctl_e   = {bus.i_read & ~bus.i_write, bus.i_write, bus.mem_ready, 1'b0};
            addr_e  = bus.i_addr;
            wdata_e = bus.i_wdata;
        end else if (owner == 2) begin
            ctl_e   = {bus.d_read & ~bus.d_write, bus.d_write, 1'b0, bus.mem_ready};
            addr_e  = bus.d_addr;
            wdata_e = bus.d_wdata;
        end
        check("rd_wr_irdy_drdy", {bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready}, ctl_e);
        check("mem_addr", bus.mem_addr, addr_e);
        check("mem_wdata", bus.mem_wdata, wdata_e);
        check("i_rdata", bus.i_rdata, bus.mem_rdata);
        check("d_rdata", bus.d_rdata, bus.mem_rdata);
        exp_i_rdy = ctl_e[1];
        exp_d_rdy = ctl_e[0];
        if (bus.i_ready) done_q.push_back(1);
        if (bus.d_ready) done_q.push_back(2);

        nxt = owner;
        if (proc_reset) begin
            nxt = 0;
        end else if (owner == 0) begin
            if (ip && dp)  nxt = (last_served == 1) ? 2 : 1;
            else if (ip)   nxt = 1;
            else if (dp)   nxt = 2;
        end else if (bus.mem_ready || (owner == 1 && !ip) || (owner == 2 && !dp)) begin
            nxt = 0;
        end
        @(posedge clk);
        if (nxt != 0 && owner == 0) last_served = nxt;
        owner = nxt;
        @(negedge clk);
    endtask

    task automatic do_reset();
        proc_reset = 1;
        step();
        proc_reset = 0;
    endtask

    // Both requesters always pending; memory answers 3 cycles into each grant.
    task automatic contention(input int want);
        int busy = 0;
        int budget = 200;
        done_q.delete();
        bus.i_read = 1; bus.i_addr = 28'h0000AAA;
        bus.d_read = 1; bus.d_addr = 28'h0000BBB;
        while (done_q.size() < want && budget > 0) begin
            if (bus.mem_read || bus.mem_write) busy++;
            else busy = 0;
            bus.mem_ready = (busy == 3);
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            budget--;
        end
        check("contention_done_count", done_q.size(), want);
        idle_all();
        step();
    endtask

    // Randomized requesters that hold requests until ready, occasionally
    // withdraw; random memory readiness; rare reset pulses.
    task automatic random_phase(input int cycles);
        bit i_act = 0, d_act = 0;
        int k;
        for (int c = 0; c < cycles; c++) begin
            if (i_act && exp_i_rdy) i_act = 0;
            if (d_act && exp_d_rdy) d_act = 0;
            if (i_act && $urandom_range(0, 39) == 0) begin
                i_act = 0; bus.i_read = 0; bus.i_write = 0;
            end
            if (d_act && $urandom_range(0, 39) == 0) begin
                d_act = 0; bus.d_read = 0; bus.d_write = 0;
            end
            if (!i_act) begin
                bus.i_read = 0; bus.i_write = 0;
                if ($urandom_range(0, 2) == 0) begin
                    i_act = 1;
                    k = $urandom_range(1, 3);
                    bus.i_read = k[0]; bus.i_write = k[1];
                    bus.i_addr = AW'($urandom);
                    bus.i_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if (!d_act) begin
                bus.d_read = 0; bus.d_write = 0;
                if ($urandom_range(0, 2) == 0) begin
                    d_act = 1;
                    k = $urandom_range(1, 3);
                    bus.d_read = k[0]; bus.d_write = k[1];
                    bus.d_addr = AW'($urandom);
                    bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 299) == 0) begin
                proc_reset = 1;
                i_act = 0; d_act = 0;
            end
            step();
            proc_reset = 0;
        end
        idle_all();
        step();
    endtask

    initial begin
        proc_reset = 1;
        idle_all();
        @(negedge clk);
        do_reset();

        // Single I-cache read.
        bus.i_read = 1; bus.i_addr = 28'h0000010;
        step();
        #1;
        check("single_mem_read", bus.mem_read, 1);
        check("single_mem_addr", bus.mem_addr, 28'h0000010);
        bus.mem_ready = 1; bus.mem_rdata = {4{32'hA5A5A5A5}};
        #1;
        check("single_i_ready", bus.i_ready, 1);
        check("single_i_rdata", bus.i_rdata, {4{32'hA5A5A5A5}});
        check("single_d_ready", bus.d_ready, 0);
        step();
        bus.i_read = 0; bus.mem_ready = 0;
        #1;
        check("single_back_idle", bus.mem_read, 0);
        step();

        // Simultaneous requests right after reset: I first, gap, then D.
        do_reset();
        bus.i_read = 1; bus.i_addr = 28'h0000020;
        bus.d_write = 1; bus.d_addr = 28'h0000030; bus.d_wdata = {4{32'hDEADBEEF}};
        step();
        #1;
        check("tie_i_first", {bus.mem_read, bus.mem_write, bus.mem_addr}, {2'b10, 28'h0000020});
        step();
        bus.mem_ready = 1;
        step();
        bus.i_read = 0; bus.mem_ready = 0;
        #1;
        check("tie_idle_gap", bus.mem_write, 0);
        step();
        #1;
        check("tie_d_write", bus.mem_write, 1);
        check("tie_d_wdata", bus.mem_wdata, {4{32'hDEADBEEF}});
        bus.mem_ready = 1;
        step();
        idle_all();
        step();

        // Contention: four transactions alternate I, D, I, D.
        do_reset();
        contention(4);
        if (done_q.size() >= 4) begin
            check("rr_order_0", done_q[0], 1);
            check("rr_order_1", done_q[1], 2);
            check("rr_order_2", done_q[2], 1);
            check("rr_order_3", done_q[3], 2);
        end

        // D write-back then allocate, one IDLE cycle apart.
        bus.d_write = 1; bus.d_addr = 28'h0000123; bus.d_wdata = {4{32'h12345678}};
        step();
        #1;
        check("wb_addr", {bus.mem_write, bus.mem_addr}, {1'b1, 28'h0000123});
        bus.mem_ready = 1;
        step();
        bus.d_write = 0; bus.d_read = 1; bus.d_addr = 28'h0000456; bus.mem_ready = 0;
        #1;
        check("wb_alloc_gap", {bus.mem_read, bus.mem_write}, 2'b00);
        step();
        #1;
        check("alloc_addr", {bus.mem_read, bus.mem_addr}, {1'b1, 28'h0000456});
        bus.mem_ready = 1;
        step();
        idle_all();
        step();

        // Reset while D owns the port: write drops without a clock edge.
        bus.d_write = 1; bus.d_addr = 28'h0000777;
        step();
        #1;
        check("pre_reset_write", bus.mem_write, 1);
        proc_reset = 1;
        #1;
        check("async_reset_write", bus.mem_write, 0);
        step();
        proc_reset = 0;
        bus.d_write = 0; bus.d_read = 1;
        bus.i_read = 1; bus.i_addr = 28'h0000888;
        step();
        #1;
        check("post_reset_tie_i", {bus.mem_read, bus.mem_addr}, {1'b1, 28'h0000888});
        idle_all();
        step();
        step();

        // Read and write together issue a write for the whole grant.
        bus.d_read = 1; bus.d_write = 1; bus.d_addr = 28'h0000999;
        step();
        for (int n = 0; n < 3; n++) begin
            #1;
            check("rw_write_only", {bus.mem_read, bus.mem_write}, 2'b01);
            step();
        end
        bus.mem_ready = 1;
        step();
        idle_all();
        step();

        random_phase(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, memory block-address width.
REQ-002 The block SHALL have parameter DATA_W, default 128, memory block-data width.
REQ-003 Ports SHALL be as follows:
- clk  input  1  single clock; all state on rising edge.
- proc_reset  input  1  asynchronous, active-high reset.
- i_read, i_write  input  1 each  I-cache request strobes.
- i_addr  input  ADDR_W  I-cache block address.
- i_wdata  input  DATA_W  I-cache write block.
- i_rdata  output  DATA_W  read block to I-cache.
- i_ready  output  1  I-cache transaction complete.
- d_read, d_write  input  1 each  D-cache request strobes.
- d_addr  input  ADDR_W  D-cache block address.
- d_wdata  input  DATA_W  D-cache write block.
- d_rdata  output  DATA_W  read block to D-cache.
- d_ready  output  1  D-cache transaction complete.
- mem_read, mem_write  output  1 each  memory request strobes.
- mem_addr  output  ADDR_W  memory block address.
- mem_wdata  output  DATA_W  memory write block.
- mem_rdata  input  DATA_W  memory read block.
- mem_ready  input  1  memory transaction complete, one-cycle pulse.

Function
REQ-004 A requester SHALL be pending when its read or write strobe is 1.
REQ-005 A requester SHALL hold its strobes, address and wdata stable until it sees its ready.
REQ-006 The state machine SHALL have three states: IDLE, GNT_I and GNT_D.
REQ-007 In IDLE with exactly one requester pending, the next state SHALL be that requester's GNT state.
REQ-008 In IDLE with both pending, the next state SHALL be GNT for the requester not in last_gnt (round-robin); last_gnt SHALL be a 1-bit register, 0 = I, 1 = D.
REQ-009 On entering GNT_x, last_gnt SHALL be updated to x.
REQ-010 In IDLE, mem_read, mem_write, i_ready and d_ready SHALL all be 0.
REQ-011 In GNT_x, mem_read, mem_write, mem_addr and mem_wdata SHALL combinationally equal x's signals.
REQ-012 If x asserts read and write together, mem_write=1 and mem_read=0 SHALL result.
REQ-013 In GNT_x, x_ready SHALL equal mem_ready; the other ready SHALL be 0.
REQ-014 i_rdata and d_rdata SHALL both equal mem_rdata at all times.
REQ-015 In IDLE, mem_addr and mem_wdata SHALL be 0.
REQ-016 In GNT_x with mem_ready=1, the next state SHALL be IDLE; otherwise the state SHALL remain GNT_x.
REQ-017 Grant SHALL never change mid-transaction; the non-granted requester SHALL wait with ready=0.
REQ-018 If x deasserts both strobes in GNT_x without mem_ready, the block SHALL return to IDLE next cycle; memory strobes then follow x (0).
REQ-019 Minimum latency, request to memory strobe: 1 cycle (IDLE->GNT).
REQ-020 Back-to-back requests by the same requester SHALL incur one IDLE cycle between transactions, e.g. D-cache write-back then allocate.
REQ-021 With both requesters continuously pending, grants SHALL alternate I, D, I, D, ....

Reset
REQ-022 proc_reset=1 SHALL immediately, without a clock edge, force state=IDLE and last_gnt=1, so I wins the first tie.
REQ-023 While in reset, mem_read, mem_write, i_ready, d_ready, mem_addr and mem_wdata SHALL all be 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction; the first grant after release SHALL follow REQ-007/REQ-008.

Verification
REQ-025 Single read: i_read=1, i_addr=28'h0000010. The bench SHALL see mem_read=1 with mem_addr=28'h0000010 from cycle 1; then mem_ready=1 with mem_rdata=128'hA5...A5 gives i_ready=1, i_rdata=A5...A5, d_ready=0, state IDLE next cycle.
REQ-026 Simultaneous requests after reset: i_read=1 and d_write=1 together. The bench SHALL see I granted first; after I's mem_ready, one IDLE cycle; then mem_write=1 with mem_wdata=d_wdata.
REQ-027 Contention: both requesters pending for 4 transactions, memory ready 3 cycles after each request. The bench SHALL see grant order I, D, I, D; at no cycle is the non-granted ready 1.
REQ-028 D write-back then allocate: d_write, addr 28'h0000123 until ready; then d_read, addr 28'h0000456. The bench SHALL see two separate memory transactions with correct addresses, separated by one IDLE cycle.
REQ-029 Reset mid-transaction: proc_reset pulsed while GNT_D with mem_ready=0. The bench SHALL see mem_write drop in the same cycle, without a clock edge, and the first tie after release grant I.
REQ-030 Read and write together: d_read=1 and d_write=1. The bench SHALL see mem_write=1 and mem_read=0 throughout the grant.
